// File: rtl/mips_pkg.sv
// Shared definitions for the forwarding MIPS pipeline: opcode/funct
// encodings, the internal ALU operation type, the bubble instruction and
// the fetch increment.
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    // SPECIAL funct codes
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    typedef enum logic [2:0] {
        ALU_NOP,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_ADD,
        ALU_SUB,
        ALU_LUI
    } aluop_t;

    // All-zero word decodes as a NOP (SPECIAL, funct 0 is unsupported)
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file with two read ports and one write port.
// Register 0 is hardwired to zero. A read of the index being written in the
// same cycle returns the write data (write-through), so the write-back stage
// never needs a separate bypass path in decode.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset (clears all)
//   i_we/i_waddr/i_wdata  : write port, committed on the rising edge
//   i_raddr_a/b, o_rdata_a/b : combinational read ports
module regfile_bypass #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [NREG-1:0][DATA_W-1:0] r_regs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_regs <= '0;
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = '0;
        o_rdata_b = '0;
        if (i_raddr_a != '0) begin
            o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_regs[i_raddr_a];
        end
        if (i_raddr_b != '0) begin
            o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_regs[i_raddr_b];
        end
    end

endmodule

// File: rtl/mips_pipe_fwd.sv
// Five-stage (IF/ID/EX/MEM/WB) MIPS integer core with full result
// forwarding into ID, an external stall and a write-back observation port.
//   clk, rst        : clock, asynchronous active-low reset
//   rom_data_i      : instruction at rom_addr_o (combinational ROM)
//   rom_addr_o      : fetch address (PC register)
//   rom_ce_o        : ROM chip enable, rises on the first edge after reset
//   stall_i         : hold PC and IF/ID, inject a bubble into EX
//   wb_we_o/wb_waddr_o/wb_wdata_o : write-back stage contents
module mips_pipe_fwd import mips_pkg::*; #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    parameter  int PC_W   = 32,
    localparam int REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       rom_data_i,
    output logic [PC_W-1:0]   rom_addr_o,
    output logic              rom_ce_o,
    input  logic              stall_i,
    output logic              wb_we_o,
    output logic [REG_AW-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o
);

    // ---------------- pipeline registers ----------------
    logic [PC_W-1:0]   r_pc;
    logic              r_ce;
    logic [31:0]       r_ifid_instr;

    aluop_t            r_idex_op;
    logic [DATA_W-1:0] r_idex_a;
    logic [DATA_W-1:0] r_idex_b;
    logic              r_idex_we;
    logic [REG_AW-1:0] r_idex_waddr;

    logic              r_exmem_we;
    logic [REG_AW-1:0] r_exmem_waddr;
    logic [DATA_W-1:0] r_exmem_data;

    logic              r_memwb_we;
    logic [REG_AW-1:0] r_memwb_waddr;
    logic [DATA_W-1:0] r_memwb_data;

    // ---------------- decode fields ----------------
    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [15:0]       w_imm;
    logic [63:0]       w_zx64;
    logic [63:0]       w_sx64;
    logic [63:0]       w_lui64;

    assign w_op    = r_ifid_instr[31:26];
    assign w_funct = r_ifid_instr[5:0];
    assign w_rs    = r_ifid_instr[21 +: REG_AW];
    assign w_rt    = r_ifid_instr[16 +: REG_AW];
    assign w_rd    = r_ifid_instr[11 +: REG_AW];
    assign w_imm   = r_ifid_instr[15:0];

    // Built at 64 bits and cut to DATA_W so narrow datapaths truncate LUI
    assign w_zx64  = {48'b0, w_imm};
    assign w_sx64  = {{48{w_imm[15]}}, w_imm};
    assign w_lui64 = {32'b0, w_imm, 16'b0};

    // Fields not every configuration consumes
    logic w_unused_bits;
    assign w_unused_bits = ^{r_ifid_instr, w_zx64, w_sx64, w_lui64};

    aluop_t            w_dec_op;
    logic              w_dec_valid;
    logic              w_dec_we;
    logic [REG_AW-1:0] w_dec_waddr;
    logic              w_use_imm;
    logic [DATA_W-1:0] w_imm_val;

    always_comb begin
        w_dec_op    = ALU_NOP;
        w_dec_valid = 1'b0;
        w_dec_waddr = '0;
        w_use_imm   = 1'b0;
        w_imm_val   = '0;
        case (w_op)
            OP_SPECIAL: begin
                w_dec_valid = 1'b1;
                w_dec_waddr = w_rd;
                case (w_funct)
                    FN_AND:  w_dec_op = ALU_AND;
                    FN_OR:   w_dec_op = ALU_OR;
                    FN_XOR:  w_dec_op = ALU_XOR;
                    FN_ADDU: w_dec_op = ALU_ADD;
                    FN_SUBU: w_dec_op = ALU_SUB;
                    default: begin
                        w_dec_valid = 1'b0;
                        w_dec_waddr = '0;
                    end
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                w_dec_valid = 1'b1;
                w_dec_waddr = w_rt;
                w_use_imm   = 1'b1;
                w_imm_val   = w_zx64[DATA_W-1:0];
                w_dec_op    = (w_op == OP_ANDI) ? ALU_AND :
                              (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_ADDIU: begin
                w_dec_valid = 1'b1;
                w_dec_waddr = w_rt;
                w_use_imm   = 1'b1;
                w_imm_val   = w_sx64[DATA_W-1:0];
                w_dec_op    = ALU_ADD;
            end
            OP_LUI: begin
                w_dec_valid = 1'b1;
                w_dec_waddr = w_rt;
                w_use_imm   = 1'b1;
                w_imm_val   = w_lui64[DATA_W-1:0];
                w_dec_op    = ALU_LUI;
            end
            default: ;
        endcase
        // A register-0 destination still flows down the pipe, just never commits
        w_dec_we = w_dec_valid && (w_dec_waddr != '0);
    end

    // ---------------- register file ----------------
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;

    regfile_bypass #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_rf (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_we      (r_memwb_we),
        .i_waddr   (r_memwb_waddr),
        .i_wdata   (r_memwb_data),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
    );

    // ---------------- EX ALU ----------------
    logic [DATA_W-1:0] w_ex_result;

    always_comb begin
        w_ex_result = '0;
        case (r_idex_op)
            ALU_AND: w_ex_result = r_idex_a & r_idex_b;
            ALU_OR:  w_ex_result = r_idex_a | r_idex_b;
            ALU_XOR: w_ex_result = r_idex_a ^ r_idex_b;
            ALU_ADD: w_ex_result = r_idex_a + r_idex_b;
            ALU_SUB: w_ex_result = r_idex_a - r_idex_b;
            ALU_LUI: w_ex_result = r_idex_b;
            default: w_ex_result = '0;
        endcase
    end

    // ---------------- ID operand forwarding ----------------
    // Youngest producer wins: EX, then MEM; the WB stage is covered by the
    // register file write-through. Recomputed every cycle, so a held ID
    // instruction picks up whatever stage its producer has moved to.
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    always_comb begin
        w_fwd_a = w_rf_a;
        if (w_rs == '0)                                  w_fwd_a = '0;
        else if (r_idex_we && (r_idex_waddr == w_rs))    w_fwd_a = w_ex_result;
        else if (r_exmem_we && (r_exmem_waddr == w_rs))  w_fwd_a = r_exmem_data;

        w_fwd_b = w_rf_b;
        if (w_rt == '0)                                  w_fwd_b = '0;
        else if (r_idex_we && (r_idex_waddr == w_rt))    w_fwd_b = w_ex_result;
        else if (r_exmem_we && (r_exmem_waddr == w_rt))  w_fwd_b = r_exmem_data;
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= '0;
            r_ce          <= 1'b0;
            r_ifid_instr  <= INSTR_NOP;
            r_idex_op     <= ALU_NOP;
            r_idex_a      <= '0;
            r_idex_b      <= '0;
            r_idex_we     <= 1'b0;
            r_idex_waddr  <= '0;
            r_exmem_we    <= 1'b0;
            r_exmem_waddr <= '0;
            r_exmem_data  <= '0;
            r_memwb_we    <= 1'b0;
            r_memwb_waddr <= '0;
            r_memwb_data  <= '0;
        end else begin
            r_ce <= 1'b1;

            // IF: the cycle with ce low presents no instruction, so load a bubble
            if (!stall_i) begin
                r_ifid_instr <= r_ce ? rom_data_i : INSTR_NOP;
                if (r_ce) begin
                    r_pc <= r_pc + PC_W'(PC_INC);
                end
            end

            // ID -> EX: a stall keeps the instruction in ID and sends a bubble on
            if (stall_i) begin
                r_idex_op    <= ALU_NOP;
                r_idex_a     <= '0;
                r_idex_b     <= '0;
                r_idex_we    <= 1'b0;
                r_idex_waddr <= '0;
            end else begin
                r_idex_op    <= w_dec_op;
                r_idex_a     <= w_fwd_a;
                r_idex_b     <= w_use_imm ? w_imm_val : w_fwd_b;
                r_idex_we    <= w_dec_we;
                r_idex_waddr <= w_dec_waddr;
            end

            // EX -> MEM -> WB always advance
            r_exmem_we    <= r_idex_we;
            r_exmem_waddr <= r_idex_waddr;
            r_exmem_data  <= w_ex_result;

            r_memwb_we    <= r_exmem_we;
            r_memwb_waddr <= r_exmem_waddr;
            r_memwb_data  <= r_exmem_data;
        end
    end

    assign rom_addr_o = r_pc;
    assign rom_ce_o   = r_ce;
    assign wb_we_o    = r_memwb_we;
    assign wb_waddr_o = r_memwb_waddr;
    assign wb_wdata_o = r_memwb_data;

endmodule

// File: tb/tb_mips_pipe_fwd.sv
`timescale 1ns/1ps
module tb_mips_pipe_fwd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int c_r         = 0;   // cyc value at reset release

    // ---------------- DUT A: 32-bit, 32 registers ----------------
    logic        rst_a = 1'b0, stall_a = 1'b0;
    logic [31:0] rom_data_a, addr_a, wdata_a;
    logic        ce_a, we_a;
    logic [4:0]  waddr_a;
    logic [31:0] rom_a [0:63];
    assign rom_data_a = rom_a[addr_a[7:2]];

    mips_pipe_fwd #(.DATA_W(32), .NREG(32), .PC_W(32)) dut_a (
        .clk(clk), .rst(rst_a), .rom_data_i(rom_data_a), .rom_addr_o(addr_a),
        .rom_ce_o(ce_a), .stall_i(stall_a), .wb_we_o(we_a),
        .wb_waddr_o(waddr_a), .wb_wdata_o(wdata_a));

    // ---------------- DUT B: 16-bit, 8 registers ----------------
    logic        rst_b = 1'b0, stall_b = 1'b0;
    logic [31:0] rom_data_b;
    logic [15:0] addr_b, wdata_b;
    logic        ce_b, we_b;
    logic [2:0]  waddr_b;
    logic [31:0] rom_b [0:63];
    assign rom_data_b = rom_b[addr_b[7:2]];

    mips_pipe_fwd #(.DATA_W(16), .NREG(8), .PC_W(16)) dut_b (
        .clk(clk), .rst(rst_b), .rom_data_i(rom_data_b), .rom_addr_o(addr_b),
        .rom_ce_o(ce_b), .stall_i(stall_b), .wb_we_o(we_b),
        .wb_waddr_o(waddr_b), .wb_wdata_o(wdata_b));

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    wb_t obs_a[$];
    wb_t obs_b[$];

    always @(negedge clk) begin
        if (rst_a && we_a) obs_a.push_back({cyc, waddr_a, wdata_a});
        if (rst_b && we_b) obs_b.push_back({cyc, {2'b0, waddr_b}, {16'b0, wdata_b}});
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic clear_roms();
        for (int i = 0; i < 64; i++) begin
            rom_a[i] = 32'h0;
            rom_b[i] = 32'h0;
        end
    endtask

    // Hold A in reset two cycles, then release on a falling edge
    task automatic start_a();
        rst_a   = 1'b0;
        stall_a = 1'b0;
        repeat (2) @(negedge clk);
        obs_a.delete();
        exp_q.delete();
        rst_a = 1'b1;
        c_r   = cyc;
    endtask

    task automatic start_b();
        rst_b   = 1'b0;
        stall_b = 1'b0;
        repeat (2) @(negedge clk);
        obs_b.delete();
        exp_q.delete();
        rst_b = 1'b1;
        c_r   = cyc;
    endtask

    // Expected write-back: offset is cycles after release (first fetch is +1, its WB +5)
    task automatic push_exp(input int off, input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({32'(c_r + off), a, d});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_roms();
        rst_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({ce_a, addr_a, we_a, waddr_a, wdata_a} !== '0) begin
                miscompares++;
                $display("FAIL reset_state: ce=%b addr=%h we=%b waddr=%0d wdata=%h, expected all 0",
                         ce_a, addr_a, we_a, waddr_a, wdata_a);
            end
        end
        rst_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (ce_a !== 1'b1 || addr_a !== 32'((k - 1) * 4) || we_a !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_fetch k=%0d: ce=%b addr=%h we=%b, expected ce=1 addr=%h we=0",
                         k, ce_a, addr_a, we_a, 32'((k - 1) * 4));
            end
        end
    endtask

    task automatic test_fwd_dist1();
        wb_t e, o;
        clear_roms();
        rom_a[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h1100);   // ORI  $1,$0,0x1100
        rom_a[1] = enc_i(6'h0D, 5'd1, 5'd2, 16'h0020);   // ORI  $2,$1,0x0020
        rom_a[2] = enc_i(6'h0D, 5'd0, 5'd1, 16'h0003);   // ORI  $1,$0,3
        rom_a[3] = enc_i(6'h0D, 5'd0, 5'd1, 16'h0004);   // ORI  $1,$0,4
        rom_a[4] = enc_i(6'h0D, 5'd1, 5'd6, 16'h0000);   // EX beats MEM -> 4
        rom_a[5] = enc_i(6'h0D, 5'd1, 5'd7, 16'h0000);   // MEM beats WB -> 4
        start_a();
        push_exp(5, 5'd1, 32'h0000_1100);
        push_exp(6, 5'd2, 32'h0000_1120);
        push_exp(7, 5'd1, 32'h0000_0003);
        push_exp(8, 5'd1, 32'h0000_0004);
        push_exp(9, 5'd6, 32'h0000_0004);
        push_exp(10, 5'd7, 32'h0000_0004);
        repeat (13) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_a.size() == 0) begin
                miscompares++;
                $display("FAIL dist1: no write-back, expected $%0d=%h at +%0d", e.addr, e.data, e.cyc - c_r);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL dist1: got $%0d=%h at +%0d, expected $%0d=%h at +%0d",
                             o.addr, o.data, o.cyc - c_r, e.addr, e.data, e.cyc - c_r);
                end
            end
        end
        vectors++;
        if (obs_a.size() != 0) begin
            miscompares++;
            $display("FAIL dist1_extra: %0d extra write-backs, expected 0", obs_a.size());
        end
    endtask

    task automatic test_fwd_dist23();
        wb_t e, o;
        clear_roms();
        rom_a[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'hFF00);   // ORI  $1,$0,0xFF00
        rom_a[2] = enc_i(6'h0C, 5'd1, 5'd3, 16'h0F0F);   // ANDI $3,$1,0x0F0F
        rom_a[3] = enc_i(6'h0E, 5'd1, 5'd4, 16'h00FF);   // XORI $4,$1,0x00FF
        rom_a[6] = enc_r(6'h21, 5'd1, 5'd3, 5'd5);       // ADDU $5,$1,$3 (from regfile)
        start_a();
        push_exp(5, 5'd1, 32'h0000_FF00);
        push_exp(7, 5'd3, 32'h0000_0F00);
        push_exp(8, 5'd4, 32'h0000_FFFF);
        push_exp(11, 5'd5, 32'h0001_0E00);
        repeat (14) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_a.size() == 0) begin
                miscompares++;
                $display("FAIL dist23: no write-back, expected $%0d=%h at +%0d", e.addr, e.data, e.cyc - c_r);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL dist23: got $%0d=%h at +%0d, expected $%0d=%h at +%0d",
                             o.addr, o.data, o.cyc - c_r, e.addr, e.data, e.cyc - c_r);
                end
            end
        end
        vectors++;
        if (obs_a.size() != 0) begin
            miscompares++;
            $display("FAIL dist23_extra: %0d extra write-backs, expected 0", obs_a.size());
        end
    endtask

    task automatic test_arith();
        wb_t e, o;
        clear_roms();
        rom_a[0] = enc_i(6'h0F, 5'd0, 5'd4, 16'h8000);   // LUI   $4,0x8000
        rom_a[1] = enc_i(6'h09, 5'd4, 5'd5, 16'hFFFF);   // ADDIU $5,$4,-1
        rom_a[2] = enc_r(6'h23, 5'd0, 5'd5, 5'd6);       // SUBU  $6,$0,$5
        rom_a[3] = enc_r(6'h24, 5'd4, 5'd5, 5'd7);       // AND   $7,$4,$5
        rom_a[4] = enc_r(6'h25, 5'd4, 5'd5, 5'd8);       // OR    $8,$4,$5
        rom_a[5] = enc_r(6'h26, 5'd5, 5'd6, 5'd9);       // XOR   $9,$5,$6
        rom_a[6] = enc_i(6'h23, 5'd0, 5'd10, 16'h0000);  // LW: unsupported
        rom_a[7] = enc_r(6'h20, 5'd4, 5'd5, 5'd11);      // ADD: unsupported
        rom_a[8] = enc_r(6'h21, 5'd6, 5'd6, 5'd10);      // ADDU $10,$6,$6 wraps
        start_a();
        push_exp(5, 5'd4, 32'h8000_0000);
        push_exp(6, 5'd5, 32'h7FFF_FFFF);
        push_exp(7, 5'd6, 32'h8000_0001);
        push_exp(8, 5'd7, 32'h0000_0000);
        push_exp(9, 5'd8, 32'hFFFF_FFFF);
        push_exp(10, 5'd9, 32'hFFFF_FFFE);
        push_exp(13, 5'd10, 32'h0000_0002);
        repeat (16) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_a.size() == 0) begin
                miscompares++;
                $display("FAIL arith: no write-back, expected $%0d=%h at +%0d", e.addr, e.data, e.cyc - c_r);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL arith: got $%0d=%h at +%0d, expected $%0d=%h at +%0d",
                             o.addr, o.data, o.cyc - c_r, e.addr, e.data, e.cyc - c_r);
                end
            end
        end
        vectors++;
        if (obs_a.size() != 0) begin
            miscompares++;
            $display("FAIL arith_extra: %0d extra write-backs, expected 0", obs_a.size());
        end
    endtask

    // Stall two cycles while LUI is in EX and its consumer ADDIU sits in ID
    task automatic test_stall();
        wb_t e, o;
        logic [31:0] exp_pc;
        clear_roms();
        rom_a[0] = enc_i(6'h0F, 5'd0, 5'd4, 16'h8000);
        rom_a[1] = enc_i(6'h09, 5'd4, 5'd5, 16'hFFFF);
        rom_a[2] = enc_r(6'h23, 5'd0, 5'd5, 5'd6);
        start_a();
        push_exp(5, 5'd4, 32'h8000_0000);
        push_exp(8, 5'd5, 32'h7FFF_FFFF);
        push_exp(9, 5'd6, 32'h8000_0001);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 6) begin
                exp_pc = (k == 6) ? 32'd12 : 32'd8;
                vectors++;
                if (addr_a !== exp_pc) begin
                    miscompares++;
                    $display("FAIL stall_pc k=%0d: addr=%h, expected %h", k, addr_a, exp_pc);
                end
            end
            stall_a = (k == 3 || k == 4);
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_a.size() == 0) begin
                miscompares++;
                $display("FAIL stall: no write-back, expected $%0d=%h at +%0d", e.addr, e.data, e.cyc - c_r);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL stall: got $%0d=%h at +%0d, expected $%0d=%h at +%0d",
                             o.addr, o.data, o.cyc - c_r, e.addr, e.data, e.cyc - c_r);
                end
            end
        end
        vectors++;
        if (obs_a.size() != 0) begin
            miscompares++;
            $display("FAIL stall_extra: %0d extra write-backs, expected 0", obs_a.size());
        end
    endtask

    // 16-bit / 8-register instance: r0 writes, index truncation, LUI truncation,
    // mid-stream reset and register clearing
    task automatic test_small();
        wb_t e, o;
        clear_roms();
        rom_b[0] = enc_i(6'h0D, 5'd0, 5'd9, 16'h1234);   // ORI   $9(=1),$0,0x1234
        rom_b[1] = enc_i(6'h0D, 5'd0, 5'd0, 16'h0005);   // ORI   $0,$0,5
        rom_b[2] = enc_r(6'h25, 5'd0, 5'd0, 5'd7);       // OR    $7,$0,$0
        rom_b[3] = enc_i(6'h09, 5'd9, 5'd2, 16'hFFFF);   // ADDIU $2,$9(=1),-1
        rom_b[4] = enc_i(6'h0F, 5'd0, 5'd3, 16'hABCD);   // LUI   $3 -> 0 at 16 bits
        start_b();
        push_exp(5, 5'd1, 32'h0000_1234);
        push_exp(7, 5'd7, 32'h0000_0000);
        push_exp(8, 5'd2, 32'h0000_1233);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                vectors++;
                if (we_b !== 1'b0 || waddr_b !== 3'd0 || wdata_b !== 16'h0005) begin
                    miscompares++;
                    $display("FAIL r0_write: we=%b waddr=%0d wdata=%h, expected we=0 waddr=0 wdata=0005",
                             we_b, waddr_b, wdata_b);
                end
            end
        end
        // Reset while $2 sits in WB, before its commit edge
        #2;
        rst_b = 1'b0;
        #1;
        vectors++;
        if ({ce_b, addr_b, we_b, waddr_b, wdata_b} !== '0) begin
            miscompares++;
            $display("FAIL midreset: ce=%b addr=%h we=%b waddr=%0d wdata=%h, expected all 0",
                     ce_b, addr_b, we_b, waddr_b, wdata_b);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_b.size() == 0) begin
                miscompares++;
                $display("FAIL small: no write-back, expected $%0d=%h at +%0d", e.addr, e.data, e.cyc - c_r);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL small: got $%0d=%h at +%0d, expected $%0d=%h at +%0d",
                             o.addr, o.data, o.cyc - c_r, e.addr, e.data, e.cyc - c_r);
                end
            end
        end
        vectors++;
        if (obs_b.size() != 0) begin
            miscompares++;
            $display("FAIL small_extra: %0d extra write-backs, expected 0", obs_b.size());
        end

        // After reset all registers read 0 and fetch restarts at 0
        clear_roms();
        rom_b[0] = enc_r(6'h25, 5'd1, 5'd2, 5'd4);       // OR   $4,$1,$2
        rom_b[1] = enc_i(6'h0E, 5'd1, 5'd5, 16'h0001);   // XORI $5,$1,1
        start_b();
        push_exp(5, 5'd4, 32'h0000_0000);
        push_exp(6, 5'd5, 32'h0000_0001);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                vectors++;
                if (addr_b !== 16'((k - 1) * 4) || ce_b !== 1'b1) begin
                    miscompares++;
                    $display("FAIL restart_fetch k=%0d: ce=%b addr=%h, expected ce=1 addr=%h",
                             k, ce_b, addr_b, 16'((k - 1) * 4));
                end
            end
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_b.size() == 0) begin
                miscompares++;
                $display("FAIL post_reset: no write-back, expected $%0d=%h at +%0d", e.addr, e.data, e.cyc - c_r);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL post_reset: got $%0d=%h at +%0d, expected $%0d=%h at +%0d",
                             o.addr, o.data, o.cyc - c_r, e.addr, e.data, e.cyc - c_r);
                end
            end
        end
        vectors++;
        if (obs_b.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_extra: %0d extra write-backs, expected 0", obs_b.size());
        end
    endtask

    initial begin
        clear_roms();
        test_reset();
        test_fwd_dist1();
        test_fwd_dist23();
        test_arith();
        test_stall();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
